// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports and one writeback port, plus a
// per-register busy scoreboard that flags RAW/WAW hazards for the issuing instruction.
module regfile_scoreboard #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS),
   localparam int CW    = $clog2(NREGS) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we3,
   input  logic [AW-1:0]   wa3,
   input  logic [XLEN-1:0] wd3,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_rd,
   input  logic            flush,
   output logic            busy1,
   output logic            busy2,
   output logic            hazard,
   output logic [CW-1:0]   pending
);

   logic [XLEN-1:0] rf_reg [NREGS];
   logic [NREGS-1:0] busy_reg;
   logic [NREGS-1:0] busy_next;
   logic [CW-1:0]    pending_reg;
   logic [CW-1:0]    pending_next;

   logic wb_en;
   logic fwd1;
   logic fwd2;
   logic fwdw;
   logic busy_w;
   logic accept;
   logic inc;
   logic dec;

   // wb_en already excludes register 0, so forwarding never applies to it
   assign wb_en = we3 && (wa3 != '0);
   assign fwd1  = (BYPASS != 0) && wb_en && (wa3 == ra1);
   assign fwd2  = (BYPASS != 0) && wb_en && (wa3 == ra2);
   assign fwdw  = (BYPASS != 0) && wb_en && (wa3 == iss_rd);

   assign rd1 = (ra1 == '0) ? '0 : (fwd1 ? wd3 : rf_reg[ra1]);
   assign rd2 = (ra2 == '0) ? '0 : (fwd2 ? wd3 : rf_reg[ra2]);

   assign busy1  = busy_reg[ra1] && !fwd1;
   assign busy2  = busy_reg[ra2] && !fwd2;
   assign busy_w = busy_reg[iss_rd] && !fwdw;

   assign hazard = iss_en && !flush && (busy1 || busy2 || busy_w);
   assign accept = iss_en && !flush && !(busy1 || busy2 || busy_w) && (iss_rd != '0);

   assign busy_next[0] = 1'b0;

   // A newly accepted issue wins over a writeback to the same register
   for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
      logic set_bit;
      logic clr_bit;
      assign set_bit = accept && (iss_rd == AW'(gi));
      assign clr_bit = wb_en && (wa3 == AW'(gi));
      assign busy_next[gi] = !flush && (set_bit || (busy_reg[gi] && !clr_bit));
   end

   always_comb begin
      inc          = accept && !busy_reg[iss_rd];
      dec          = wb_en && busy_reg[wa3] && !(accept && (iss_rd == wa3));
      pending_next = pending_reg;
      if (flush) begin
         pending_next = '0;
      end else begin
         pending_next = pending_reg + CW'(inc) - CW'(dec);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_reg    <= '0;
         pending_reg <= '0;
      end else begin
         busy_reg    <= busy_next;
         pending_reg <= pending_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_reg[i] <= '0;
         end
      end else if (wb_en) begin
         rf_reg[wa3] <= wd3;
      end
   end

   assign pending = pending_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: a BYPASS=1 and a BYPASS=0 instance share stimulus and are
// compared against an array-based reference model of the register file and scoreboard.
module tb_regfile_scoreboard;

   logic        clk;
   logic        reset;
   logic        we3;
   logic [4:0]  wa3;
   logic [31:0] wd3;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic        iss_en;
   logic [4:0]  iss_rd;
   logic        flush;

   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic        busy1_b, busy2_b, hazard_b, busy1_n, busy2_n, hazard_n;
   logic [5:0]  pend_b, pend_n;

   logic [31:0] rd1_o [2];
   logic [31:0] rd2_o [2];
   logic        busy1_o [2];
   logic        busy2_o [2];
   logic        hazard_o [2];
   logic [5:0]  pend_o [2];

   assign rd1_o[0] = rd1_b;   assign rd1_o[1] = rd1_n;
   assign rd2_o[0] = rd2_b;   assign rd2_o[1] = rd2_n;
   assign busy1_o[0] = busy1_b; assign busy1_o[1] = busy1_n;
   assign busy2_o[0] = busy2_b; assign busy2_o[1] = busy2_n;
   assign hazard_o[0] = hazard_b; assign hazard_o[1] = hazard_n;
   assign pend_o[0] = pend_b; assign pend_o[1] = pend_n;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: index 0 mirrors the forwarding instance, index 1 the plain one
   logic [31:0] m_rf   [2][32];
   bit          m_busy [2][32];

   regfile_scoreboard #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_byp (
      .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
      .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
      .busy1(busy1_b), .busy2(busy2_b), .hazard(hazard_b), .pending(pend_b)
   );

   regfile_scoreboard #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_nobyp (
      .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
      .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
      .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
      .busy1(busy1_n), .busy2(busy2_n), .hazard(hazard_n), .pending(pend_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit exp_fwd(int d, logic [4:0] a);
      return (d == 0) && we3 && (wa3 == a) && (a != 0);
   endfunction

   function automatic logic [31:0] exp_rd(int d, logic [4:0] a);
      if (a == 0) return 32'h0;
      if (exp_fwd(d, a)) return wd3;
      return m_rf[d][a];
   endfunction

   function automatic bit exp_busy(int d, logic [4:0] a);
      return (a != 0) && !exp_fwd(d, a) && m_busy[d][a];
   endfunction

   function automatic bit exp_hazard(int d);
      return iss_en && !flush && (exp_busy(d, ra1) || exp_busy(d, ra2) || exp_busy(d, iss_rd));
   endfunction

   function automatic int exp_pending(int d);
      int cnt = 0;
      for (int r = 0; r < 32; r++) cnt += int'(m_busy[d][r]);
      return cnt;
   endfunction

   task automatic model_step();
      bit acc [2];
      for (int d = 0; d < 2; d++)
         acc[d] = iss_en && !exp_hazard(d) && !flush && (iss_rd != 0);
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            for (int r = 0; r < 32; r++) begin
               m_rf[d][r] = 32'h0;
               m_busy[d][r] = 1'b0;
            end
         end else begin
            if (we3 && wa3 != 0) begin
               m_rf[d][wa3] = wd3;
               m_busy[d][wa3] = 1'b0;
            end
            if (acc[d]) m_busy[d][iss_rd] = 1'b1;
            if (flush) for (int r = 0; r < 32; r++) m_busy[d][r] = 1'b0;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
      iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      ra1 = 5'd9; ra2 = 5'd17; iss_en = 1'b1; iss_rd = 5'd4;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (rd1_o[d] !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 dut%0d: got %h want 0", d, rd1_o[d]); end
         n_checks++; if (rd2_o[d] !== 32'h0) begin n_fail++; $display("FAIL reset_rd2 dut%0d: got %h want 0", d, rd2_o[d]); end
         n_checks++; if (busy1_o[d] !== 1'b0 || busy2_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b%b want 00", d, busy1_o[d], busy2_o[d]); end
         n_checks++; if (hazard_o[d] !== 1'b0) begin n_fail++; $display("FAIL reset_hazard dut%0d: got %b want 0", d, hazard_o[d]); end
         n_checks++; if (pend_o[d] !== 6'd0) begin n_fail++; $display("FAIL reset_pending dut%0d: got %0d want 0", d, pend_o[d]); end
      end
      idle();
      $display("test_reset done");
   endtask

   task automatic test_write_read();
      idle();
      we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hDEADBEEF;
      tick();
      idle();
      ra1 = 5'd5; ra2 = 5'd0;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (rd1_o[d] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_rd1 dut%0d: got %h want deadbeef", d, rd1_o[d]); end
         n_checks++; if (rd2_o[d] !== 32'h0) begin n_fail++; $display("FAIL wr_rd_rd2 dut%0d: got %h want 0", d, rd2_o[d]); end
      end
      $display("test_write_read done");
   endtask

   task automatic test_reg0();
      idle();
      we3 = 1'b1; wa3 = 5'd0; wd3 = 32'h1234;
      tick();
      idle();
      ra1 = 5'd0; iss_en = 1'b1; iss_rd = 5'd0;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (rd1_o[d] !== 32'h0) begin n_fail++; $display("FAIL reg0_rd1 dut%0d: got %h want 0", d, rd1_o[d]); end
         n_checks++; if (hazard_o[d] !== 1'b0) begin n_fail++; $display("FAIL reg0_hazard dut%0d: got %b want 0", d, hazard_o[d]); end
      end
      tick();
      idle();
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (pend_o[d] !== 6'd0) begin n_fail++; $display("FAIL reg0_pending dut%0d: got %0d want 0", d, pend_o[d]); end
         n_checks++; if (busy1_o[d] !== 1'b0) begin n_fail++; $display("FAIL reg0_busy1 dut%0d: got %b want 0", d, busy1_o[d]); end
      end
      $display("test_reg0 done");
   endtask

   task automatic test_bypass();
      idle();
      we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h11;
      tick();
      wd3 = 32'h22; ra1 = 5'd7;
      #1;
      n_checks++; if (rd1_b !== 32'h22) begin n_fail++; $display("FAIL bypass_rd1 byp: got %h want 22", rd1_b); end
      n_checks++; if (busy1_b !== 1'b0) begin n_fail++; $display("FAIL bypass_busy1 byp: got %b want 0", busy1_b); end
      n_checks++; if (rd1_n !== 32'h11) begin n_fail++; $display("FAIL bypass_rd1 nobyp: got %h want 11", rd1_n); end
      tick();
      idle();
      ra1 = 5'd7;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (rd1_o[d] !== 32'h22) begin n_fail++; $display("FAIL bypass_commit dut%0d: got %h want 22", d, rd1_o[d]); end
      end
      $display("test_bypass done");
   endtask

   task automatic test_issue();
      idle();
      iss_en = 1'b1; iss_rd = 5'd3;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (hazard_o[d] !== 1'b0) begin n_fail++; $display("FAIL issue_free_hazard dut%0d: got %b want 0", d, hazard_o[d]); end
      end
      tick();
      iss_rd = 5'd9; ra1 = 5'd3;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (pend_o[d] !== 6'd1) begin n_fail++; $display("FAIL issue_pending dut%0d: got %0d want 1", d, pend_o[d]); end
         n_checks++; if (busy1_o[d] !== 1'b1) begin n_fail++; $display("FAIL issue_raw_busy1 dut%0d: got %b want 1", d, busy1_o[d]); end
         n_checks++; if (hazard_o[d] !== 1'b1) begin n_fail++; $display("FAIL issue_raw_hazard dut%0d: got %b want 1", d, hazard_o[d]); end
      end
      iss_rd = 5'd3; ra1 = 5'd0;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (hazard_o[d] !== 1'b1) begin n_fail++; $display("FAIL issue_waw_hazard dut%0d: got %b want 1", d, hazard_o[d]); end
      end
      tick();
      idle();
      we3 = 1'b1; wa3 = 5'd3; wd3 = 32'h33;
      tick();
      idle();
      ra1 = 5'd3;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (busy1_o[d] !== 1'b0) begin n_fail++; $display("FAIL issue_wb_busy1 dut%0d: got %b want 0", d, busy1_o[d]); end
         n_checks++; if (pend_o[d] !== 6'd0) begin n_fail++; $display("FAIL issue_wb_pending dut%0d: got %0d want 0", d, pend_o[d]); end
      end
      $display("test_issue done");
   endtask

   task automatic test_set_wins();
      idle();
      iss_en = 1'b1; iss_rd = 5'd4;
      tick();
      we3 = 1'b1; wa3 = 5'd4; wd3 = 32'hA5A5;
      #1;
      n_checks++; if (hazard_b !== 1'b0) begin n_fail++; $display("FAIL setwins_hazard byp: got %b want 0", hazard_b); end
      n_checks++; if (hazard_n !== 1'b1) begin n_fail++; $display("FAIL setwins_hazard nobyp: got %b want 1", hazard_n); end
      tick();
      idle();
      ra1 = 5'd4;
      #1;
      n_checks++; if (pend_b !== 6'd1) begin n_fail++; $display("FAIL setwins_pending byp: got %0d want 1", pend_b); end
      n_checks++; if (busy1_b !== 1'b1) begin n_fail++; $display("FAIL setwins_busy byp: got %b want 1", busy1_b); end
      n_checks++; if (pend_n !== 6'd0) begin n_fail++; $display("FAIL setwins_pending nobyp: got %0d want 0", pend_n); end
      n_checks++; if (busy1_n !== 1'b0) begin n_fail++; $display("FAIL setwins_busy nobyp: got %b want 0", busy1_n); end
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (rd1_o[d] !== 32'hA5A5) begin n_fail++; $display("FAIL setwins_data dut%0d: got %h want a5a5", d, rd1_o[d]); end
      end
      idle();
      we3 = 1'b1; wa3 = 5'd4; wd3 = 32'hA5A5;
      tick();
      idle();
      $display("test_set_wins done");
   endtask

   task automatic test_flush();
      idle();
      for (int r = 1; r <= 3; r++) begin
         iss_en = 1'b1; iss_rd = 5'(r);
         tick();
      end
      idle();
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (pend_o[d] !== 6'd3) begin n_fail++; $display("FAIL flush_pre_pending dut%0d: got %0d want 3", d, pend_o[d]); end
      end
      flush = 1'b1; we3 = 1'b1; wa3 = 5'd2; wd3 = 32'h55; iss_en = 1'b1; iss_rd = 5'd6;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (hazard_o[d] !== 1'b0) begin n_fail++; $display("FAIL flush_hazard dut%0d: got %b want 0", d, hazard_o[d]); end
      end
      tick();
      idle();
      ra1 = 5'd2; ra2 = 5'd6;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (pend_o[d] !== 6'd0) begin n_fail++; $display("FAIL flush_pending dut%0d: got %0d want 0", d, pend_o[d]); end
         n_checks++; if (rd1_o[d] !== 32'h55) begin n_fail++; $display("FAIL flush_data dut%0d: got %h want 55", d, rd1_o[d]); end
         n_checks++; if (busy2_o[d] !== 1'b0) begin n_fail++; $display("FAIL flush_busy6 dut%0d: got %b want 0", d, busy2_o[d]); end
      end
      for (int r = 1; r <= 3; r++) begin
         ra1 = 5'(r);
         #1;
         for (int d = 0; d < 2; d++) begin
            n_checks++; if (busy1_o[d] !== 1'b0) begin n_fail++; $display("FAIL flush_busy%0d dut%0d: got %b want 0", r, d, busy1_o[d]); end
         end
      end
      $display("test_flush done");
   endtask

   task automatic test_reset_mid();
      idle();
      iss_en = 1'b1; iss_rd = 5'd5;
      tick();
      idle();
      ra1 = 5'd5; ra2 = 5'd2; reset = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (busy1_o[d] !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_busy dut%0d: got %b want 1", d, busy1_o[d]); end
         n_checks++; if (pend_o[d] !== 6'd1) begin n_fail++; $display("FAIL rstmid_pre_pending dut%0d: got %0d want 1", d, pend_o[d]); end
      end
      tick();
      reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (busy1_o[d] !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy dut%0d: got %b want 0", d, busy1_o[d]); end
         n_checks++; if (pend_o[d] !== 6'd0) begin n_fail++; $display("FAIL rstmid_pending dut%0d: got %0d want 0", d, pend_o[d]); end
         n_checks++; if (rd2_o[d] !== 32'h0) begin n_fail++; $display("FAIL rstmid_rd2 dut%0d: got %h want 0", d, rd2_o[d]); end
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         reset  = ($urandom_range(0, 99) == 0);
         flush  = ($urandom_range(0, 15) == 0);
         we3    = $urandom_range(0, 1);
         wa3    = 5'($urandom_range(0, 7));
         wd3    = $urandom;
         ra1    = 5'($urandom_range(0, 7));
         ra2    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         iss_en = $urandom_range(0, 1);
         iss_rd = 5'($urandom_range(0, 7));
         #1;
         for (int d = 0; d < 2; d++) begin
            n_checks++; if (rd1_o[d] !== exp_rd(d, ra1)) begin n_fail++; $display("FAIL rand_rd1 cyc%0d dut%0d: got %h want %h", c, d, rd1_o[d], exp_rd(d, ra1)); end
            n_checks++; if (rd2_o[d] !== exp_rd(d, ra2)) begin n_fail++; $display("FAIL rand_rd2 cyc%0d dut%0d: got %h want %h", c, d, rd2_o[d], exp_rd(d, ra2)); end
            n_checks++; if (busy1_o[d] !== exp_busy(d, ra1)) begin n_fail++; $display("FAIL rand_busy1 cyc%0d dut%0d: got %b want %b", c, d, busy1_o[d], exp_busy(d, ra1)); end
            n_checks++; if (busy2_o[d] !== exp_busy(d, ra2)) begin n_fail++; $display("FAIL rand_busy2 cyc%0d dut%0d: got %b want %b", c, d, busy2_o[d], exp_busy(d, ra2)); end
            n_checks++; if (hazard_o[d] !== exp_hazard(d)) begin n_fail++; $display("FAIL rand_hazard cyc%0d dut%0d: got %b want %b", c, d, hazard_o[d], exp_hazard(d)); end
            n_checks++; if (pend_o[d] !== 6'(exp_pending(d))) begin n_fail++; $display("FAIL rand_pending cyc%0d dut%0d: got %0d want %0d", c, d, pend_o[d], exp_pending(d)); end
         end
         tick();
      end
      idle();
      $display("test_random done");
   endtask

   initial begin
      idle();
      @(posedge clk);
      #1;
      test_reset();
      test_write_read();
      test_reg0();
      test_bypass();
      test_issue();
      test_set_wins();
      test_flush();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count (power of two, >=2); AW = log2(NREGS), CW = log2(NREGS)+1.
REQ-003 Parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 we3  input  1  writeback enable.
REQ-007 wa3  input  AW  writeback register address.
REQ-008 wd3  input  XLEN  writeback data.
REQ-009 ra1, ra2  input  AW each  read addresses (issuing instruction's sources).
REQ-010 rd1, rd2  output  XLEN each  read data.
REQ-011 iss_en  input  1  instruction issue request, will write iss_rd.
REQ-012 iss_rd  input  AW  destination register of issuing instruction.
REQ-013 flush  input  1  pipeline flush; clears all pending state.
REQ-014 busy1, busy2  output  1 each  source ra1/ra2 has an outstanding writer.
REQ-015 hazard  output  1  iss_en asserted and issue must stall.
REQ-016 pending  output  CW  count of busy registers.

Function
REQ-017 Register 0 SHALL read as 0, never be written, never be busy.
REQ-018 On rising edge with we3=1 and wa3!=0, rf[wa3] SHALL take wd3; visible on rd next cycle (or same cycle per REQ-019).
REQ-019 BYPASS=1: rdN SHALL equal wd3 when we3=1, wa3=raN, raN!=0; otherwise rf[raN]. BYPASS=0: rdN = rf[raN] always.
REQ-020 Reads SHALL be combinational from ra1/ra2; no read latency.
REQ-021 Scoreboard: one busy bit per register; busy[0] constant 0.
REQ-022 busyN SHALL = busy[raN], forced 0 when raN=0 or (BYPASS=1, we3=1, wa3=raN).
REQ-023 hazard SHALL = iss_en & !flush & (busy1 | busy2 | busy_w), busy_w = busy[iss_rd] with the same forwarding/zero rules as REQ-022 (WAW check).
REQ-024 Issue accepted when iss_en=1, hazard=0, flush=0, iss_rd!=0: busy[iss_rd] SHALL set next edge.
REQ-025 we3=1, wa3!=0: busy[wa3] SHALL clear next edge.
REQ-026 Accepted issue and writeback to same register same cycle: set wins; busy stays 1, data still written.
REQ-027 flush=1: all busy bits and pending SHALL clear next edge; a concurrent we3 write SHALL still commit data; concurrent iss_en SHALL be ignored.
REQ-028 Writeback to a non-busy register SHALL write data and leave busy 0 (no underflow).
REQ-029 pending SHALL be a registered counter equal to popcount(busy) every cycle: +1 on set of a clear bit, -1 on clear of a set bit, net 0 when both or neither; never exceeds NREGS-1, never below 0.
REQ-030 rd1/rd2/busyN/hazard SHALL depend only on current inputs and current state (no extra pipeline stage).

Reset
REQ-031 reset=1 at an edge SHALL set all rf entries to 0, all busy bits to 0, pending to 0; reset overrides we3, iss_en, flush.
REQ-032 During reset assertion outputs SHALL reflect pre-reset state until the first edge; after it rd1=rd2=0, busy1=busy2=0, hazard=iss_en&0=0, pending=0.
REQ-033 Reset mid-operation SHALL discard all outstanding busy state with no residual count.

Verification
REQ-034 Reset, then we3=1 wa3=5 wd3=0xDEADBEEF; next cycle ra1=5 -> rd1=0xDEADBEEF; ra2=0 -> rd2=0.
REQ-035 we3=1 wa3=0 wd3=0x1234; next cycle ra1=0 -> rd1=0; iss_en iss_rd=0 -> busy bit 0 never set, pending=0.
REQ-036 BYPASS=1: rf[7]=0x11, same cycle we3 wa3=7 wd3=0x22 with ra1=7 -> rd1=0x22, busy1=0; BYPASS=0 same stimulus -> rd1=0x11.
REQ-037 Issue iss_rd=3 -> pending=1; next cycle ra1=3 iss_en -> busy1=1, hazard=1; iss_rd=3 (WAW) -> hazard=1; we3 wa3=3 -> next cycle busy1=0, pending=0.
REQ-038 busy[4]=1; same cycle issue iss_rd=4 (ra1/ra2 clear, forwarded busy_w=0) and we3 wa3=4 -> busy[4]=1, pending unchanged, rf[4]=wd3.
REQ-039 Issue to regs 1,2,3 (pending=3), then flush with we3 wa3=2 wd3=0x55 and iss_en iss_rd=6 -> pending=0, all busy 0, rf[2]=0x55, reg 6 not busy.
